// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external 4-bit combinational ALU
// between two req/ack requesters. Each accepted request is latched and
// presented to the ALU, then its result is captured and returned with a
// one-cycle ack. The last result also drives a 0-9 seven-segment display
// register, and completed operations are counted.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3,
  parameter int CNT_W = 8
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             ack1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [3:0]       disp_code,
  output logic             disp_blank,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Opcodes the ALU actually implements; anything else is flagged.
  localparam logic [OPW-1:0] OP_NOT = OPW'(0);
  localparam logic [OPW-1:0] OP_AND = OPW'(1);
  localparam logic [OPW-1:0] OP_OR  = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [3:0]       disp_code_q, disp_code_d;
  logic             disp_blank_q, disp_blank_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             op_legal;
  logic             pick1;

  // Legality of the opcode currently presented to the ALU.
  always_comb begin
    op_legal = (alu_op_q == OP_NOT) || (alu_op_q == OP_AND) ||
               (alu_op_q == OP_OR)  || (alu_op_q == OP_XOR);
  end

  // Next-state logic: arbitration in IDLE, result capture in ISSUE,
  // bookkeeping (round-robin pointer, display, counter) in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    disp_code_d  = disp_code_q;
    disp_blank_d = disp_blank_q;
    op_count_d   = op_count_q;
    // Requester 1 wins when it is alone, or on a tie when 0 went last.
    pick1        = req1 && (!req0 || !last_grant_q);
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d    = pick1;
          alu_a_d  = pick1 ? a1  : a0;
          alu_b_d  = pick1 ? b1  : b0;
          alu_op_d = pick1 ? op1 : op0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        rsp_data_d = alu_result;
        rsp_err_d  = !op_legal;
        state_d    = RESP;
      end
      RESP: begin
        last_grant_d = gnt_q;
        disp_code_d  = rsp_data_q[3:0];
        disp_blank_d = (rsp_data_q > WIDTH'(9));
        op_count_d   = op_count_q + CNT_W'(1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      disp_code_q  <= 4'd0;
      disp_blank_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      disp_code_q  <= disp_code_d;
      disp_blank_q <= disp_blank_d;
      op_count_q   <= op_count_d;
    end
  end

  // Acks and busy decode straight from state so reset clears them at once.
  always_comb begin
    ack0       = (state_q == RESP) && !gnt_q;
    ack1       = (state_q == RESP) &&  gnt_q;
    busy       = (state_q != IDLE);
    rsp_data   = rsp_data_q;
    rsp_err    = rsp_err_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_op     = alu_op_q;
    disp_code  = disp_code_q;
    disp_blank = disp_blank_q;
    op_count   = op_count_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: the driver raises requests and pushes the
// expected response of each grant into a queue; an independent monitor pops
// and compares whenever an ack appears.
module tb_alu_arbiter;

  logic       CLOCK_50;
  logic       RST_N;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       ack0, ack1;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       busy;
  logic [3:0] disp_code;
  logic       disp_blank;
  logic [7:0] op_count;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit         who;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] data;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  bit   last_m = 1'b1;   // reference round-robin pointer
  bit   abort  = 1'b0;

  // Reference ALU: NOT a, AND, OR, XOR; unsupported opcodes give zero.
  function automatic logic [3:0] ref_alu(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit ref_err(logic [2:0] op);
    return !(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4);
  endfunction

  // The shared ALU lives outside the arbiter.
  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  alu_arbiter #(.WIDTH(4), .OPW(3), .CNT_W(8)) dut (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .req0       (req0),
    .a0         (a0),
    .b0         (b0),
    .op0        (op0),
    .ack0       (ack0),
    .req1       (req1),
    .a1         (a1),
    .b1         (b1),
    .op1        (op1),
    .ack1       (ack1),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .disp_code  (disp_code),
    .disp_blank (disp_blank),
    .op_count   (op_count)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_ack0"},       32'(ack0),       0);
    chk({tag, "_ack1"},       32'(ack1),       0);
    chk({tag, "_rsp_data"},   32'(rsp_data),   0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    0);
    chk({tag, "_alu_a"},      32'(alu_a),      0);
    chk({tag, "_alu_b"},      32'(alu_b),      0);
    chk({tag, "_alu_op"},     32'(alu_op),     0);
    chk({tag, "_disp_code"},  32'(disp_code),  0);
    chk({tag, "_disp_blank"}, 32'(disp_blank), 0);
    chk({tag, "_op_count"},   32'(op_count),   0);
  endtask

  // Monitor: on every ack compare against the oldest expectation, then check
  // the display/counter update one cycle later.
  initial begin
    exp_t       e;
    int         exp_cnt   = 0;
    bit         disp_pend = 0;
    logic [3:0] exp_disp  = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!RST_N) begin
        exp_cnt   = 0;
        disp_pend = 0;
        continue;
      end
      if (disp_pend) begin
        chk("disp_code",  32'(disp_code),  32'(exp_disp));
        chk("disp_blank", 32'(disp_blank), 32'(exp_disp > 4'd9));
        chk("op_count",   32'(op_count),   32'(exp_cnt[7:0]));
        disp_pend = 0;
      end
      if (ack0 || ack1) begin
        chk("ack_exclusive", 32'(ack0 & ack1), 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b required none", ack0, ack1);
        end else begin
          e = exp_q.pop_front();
          $display("txn: grant=%0d a=%h b=%h op=%0d data=%h err=%0b (exp %h/%0b)",
                   ack1, alu_a, alu_b, alu_op, rsp_data, rsp_err, e.data, e.err);
          chk("grant",       32'(ack1),     32'(e.who));
          chk("rsp_data",    32'(rsp_data), 32'(e.data));
          chk("rsp_err",     32'(rsp_err),  32'(e.err));
          chk("alu_a",       32'(alu_a),    32'(e.a));
          chk("alu_b",       32'(alu_b),    32'(e.b));
          chk("alu_op",      32'(alu_op),   32'(e.op));
          chk("busy_in_ack", 32'(busy),     1);
          chk("count_pre",   32'(op_count), 32'(exp_cnt[7:0]));
          exp_cnt++;
          exp_disp  = e.data;
          disp_pend = 1;
        end
      end
    end
  end

  // Predict the next winner from the currently raised requests and queue it.
  function automatic bit predict_and_push();
    exp_t e;
    bit   w;
    w = (req0 && req1) ? !last_m : req1;
    e.who  = w;
    e.a    = w ? a1 : a0;
    e.b    = w ? b1 : b0;
    e.op   = w ? op1 : op0;
    e.data = ref_alu(e.a, e.b, e.op);
    e.err  = ref_err(e.op);
    exp_q.push_back(e);
    last_m = w;
    return w;
  endfunction

  // Bounded wait for the ack; at the ack cycle the winner drops req unless
  // it chooses to re-request.
  task automatic wait_ack(input bit w, input bit keep);
    bit got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK_50);
      if (ack0 || ack1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack in 8 cycles, required ack%0d", w);
      abort = 1;
      return;
    end
    if (!keep) begin
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
    end
  endtask

  task automatic round(input bit w0, input bit w1, input bit keep,
                       input logic [3:0] na0, input logic [3:0] nb0, input logic [2:0] nop0,
                       input logic [3:0] na1, input logic [3:0] nb1, input logic [2:0] nop1,
                       input int gap);
    bit w;
    if (abort) return;
    if (!req0 && !req1) repeat (gap) @(negedge CLOCK_50);
    if (w0 && !req0) begin req0 = 1'b1; a0 = na0; b0 = nb0; op0 = nop0; end
    if (w1 && !req1) begin req1 = 1'b1; a1 = na1; b1 = nb1; op1 = nop1; end
    if (!req0 && !req1) return;
    w = predict_and_push();
    wait_ack(w, keep);
  endtask

  // Global time guard.
  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    bit w;
    RST_N = 1'b0;
    req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0;
    a1 = 0; b1 = 0; op1 = 0;
    repeat (3) @(negedge CLOCK_50);
    chk_all_zero("in_reset");
    RST_N = 1'b1;

    // Idle after reset: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_acks", 32'({ack0, ack1}), 0);
    end
    chk_all_zero("idle");

    // Tie held through several grants: 0,1,0,1 then drain.
    round(1, 1, 1, 4'b0110, 4'b0101, 3'd4, 4'b0110, 4'b0101, 3'd0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    round(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    round(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    round(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single requests from the test plan.
    round(1, 0, 0, 4'b0110, 4'b0101, 3'd1, 0, 0, 0, 2);
    round(0, 1, 0, 0, 0, 0, 4'b1011, 4'b0111, 3'd3, 1);
    round(1, 0, 0, 4'b0010, 4'b0000, 3'd0, 0, 0, 0, 0);

    // Random traffic, including re-requests and held losers.
    for (int i = 0; i < 300; i++) begin
      round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 4 && (req0 || req1); i++) begin
      round(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Reset in the middle of ISSUE drops the operation; held req0 is then served.
    if (!abort) begin
      repeat (3) @(negedge CLOCK_50);
      req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0101; op0 = 3'd2;
      @(negedge CLOCK_50);
      chk("issue_busy", 32'(busy), 1);
      RST_N = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      last_m = 1'b1;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      w = predict_and_push();
      RST_N = 1'b1;
      wait_ack(w, 0);
    end

    repeat (4) @(negedge CLOCK_50);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
